// File: rtl/fac_pkg.sv
// Shared definitions for the factorial calculator and its bus master:
// register map offsets, data width and the master sequencer state encoding.
package fac_pkg;

  localparam int DATA_W = 64;

  // Register offsets relative to the calculator base address
  localparam logic [15:0] OFF_OPSTART  = 16'h0000;
  localparam logic [15:0] OFF_OPCLEAR  = 16'h0008;
  localparam logic [15:0] OFF_OPDONE   = 16'h0010;
  localparam logic [15:0] OFF_INTREN   = 16'h0018;
  localparam logic [15:0] OFF_OPERAND  = 16'h0020;
  localparam logic [15:0] OFF_RESULT_H = 16'h0028;
  localparam logic [15:0] OFF_RESULT_L = 16'h0030;

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_W_OPND,
    S_W_CLR1,
    S_W_CLR0,
    S_W_START,
    S_WAIT_INT,
    S_R_H,
    S_R_L,
    S_W_CLR_DONE,
    S_OUT
  } fac_state_t;

endpackage

// File: rtl/fac_master_bus_access.sv
// Single-access bus engine. A start pulse loads address/direction/data into
// the registered bus outputs and raises m_req; the access completes on the
// edge where m_req & m_grant. A new start on the completing edge chains the
// next access without a gap. Without grant every bus output is frozen.
module bus_access
  import fac_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              acc_wr,
  input  logic [15:0]       acc_addr,
  input  logic [DATA_W-1:0] acc_data,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              m_req,
  output logic              m_wr,
  output logic [15:0]       m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic              m_grant,
  input  logic [DATA_W-1:0] m_din
);

  // Completion is visible to the sequencer in the same cycle so it can
  // capture read data and issue the follow-on access on the same edge.
  assign done    = m_req & m_grant;
  assign rd_data = m_din;

  // Load a new access on start, release the bus when an access finishes alone
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_req  <= 1'b0;
      m_wr   <= 1'b0;
      m_addr <= '0;
      m_dout <= '0;
    end else if (start) begin
      m_req  <= 1'b1;
      m_wr   <= acc_wr;
      m_addr <= acc_addr;
      m_dout <= acc_data;
    end else if (done) begin
      m_req  <= 1'b0;
    end
  end

endmodule

// File: rtl/fac_master.sv
// Factorial command sequencer: accepts an operand, programs the calculator
// over the master bus, waits for its interrupt, reads both result words and
// hands them out together with the measured calculation latency.
module fac_master
  import fac_pkg::*;
#(
  parameter logic [15:0] BASE  = 16'h7000,
  parameter int          CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  input  logic [63:0]       cmd_operand,
  output logic              cmd_ready,
  output logic              res_valid,
  output logic [63:0]       res_h,
  output logic [63:0]       res_l,
  output logic [CNT_W-1:0]  res_cycles,
  input  logic              res_ready,
  output logic              m_req,
  output logic              m_wr,
  output logic [15:0]       m_addr,
  output logic [63:0]       m_dout,
  input  logic              m_grant,
  input  logic [63:0]       m_din,
  input  logic              interrupt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fac_state_t         state_reg;
  logic               clr_phase_reg;
  logic               int_prev_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_next;
  logic               int_rise;

  logic               acc_start;
  logic               acc_wr;
  logic [15:0]        acc_addr;
  logic [DATA_W-1:0]  acc_data;
  logic               acc_done;
  logic [DATA_W-1:0]  acc_rd_data;

  // Edge detector tracks the pin every cycle so a level already high on
  // entry to WAIT_INT is not mistaken for a fresh completion.
  assign int_rise = interrupt & ~int_prev_reg;
  assign cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

  bus_access u_bus (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (acc_start),
    .acc_wr   (acc_wr),
    .acc_addr (acc_addr),
    .acc_data (acc_data),
    .done     (acc_done),
    .rd_data  (acc_rd_data),
    .m_req    (m_req),
    .m_wr     (m_wr),
    .m_addr   (m_addr),
    .m_dout   (m_dout),
    .m_grant  (m_grant),
    .m_din    (m_din)
  );

  // Choose the next bus access, issued on the edge the previous one completes
  always_comb begin
    acc_start = 1'b0;
    acc_wr    = 1'b1;
    acc_addr  = BASE;
    acc_data  = '0;
    unique case (state_reg)
      S_INIT: begin
        if (!m_req) begin
          acc_start = 1'b1;
          acc_addr  = BASE + OFF_INTREN;
          acc_data  = 64'd1;
        end
      end
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          acc_start = 1'b1;
          acc_addr  = BASE + OFF_OPERAND;
          acc_data  = cmd_operand;
        end
      end
      S_W_OPND: begin
        if (acc_done) begin
          acc_start = 1'b1;
          acc_addr  = BASE + OFF_OPCLEAR;
          acc_data  = 64'd1;
        end
      end
      S_W_CLR1: begin
        if (acc_done) begin
          acc_start = 1'b1;
          acc_addr  = BASE + OFF_OPCLEAR;
          acc_data  = 64'd0;
        end
      end
      S_W_CLR0: begin
        if (acc_done) begin
          acc_start = 1'b1;
          acc_addr  = BASE + OFF_OPSTART;
          acc_data  = 64'd1;
        end
      end
      S_WAIT_INT: begin
        if (int_rise) begin
          acc_start = 1'b1;
          acc_wr    = 1'b0;
          acc_addr  = BASE + OFF_RESULT_H;
        end
      end
      S_R_H: begin
        if (acc_done) begin
          acc_start = 1'b1;
          acc_wr    = 1'b0;
          acc_addr  = BASE + OFF_RESULT_L;
        end
      end
      S_R_L: begin
        if (acc_done) begin
          acc_start = 1'b1;
          acc_addr  = BASE + OFF_OPCLEAR;
          acc_data  = 64'd1;
        end
      end
      S_W_CLR_DONE: begin
        if (acc_done && !clr_phase_reg) begin
          acc_start = 1'b1;
          acc_addr  = BASE + OFF_OPCLEAR;
          acc_data  = 64'd0;
        end
      end
      default: begin
        acc_start = 1'b0;
      end
    endcase
  end

  // Sequencer state, latency counter and registered command/result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_INIT;
      clr_phase_reg <= 1'b0;
      int_prev_reg  <= 1'b0;
      cnt_reg       <= '0;
      cmd_ready     <= 1'b0;
      res_valid     <= 1'b0;
      res_h         <= '0;
      res_l         <= '0;
      res_cycles    <= '0;
    end else begin
      int_prev_reg <= interrupt;
      unique case (state_reg)
        S_INIT: begin
          if (acc_done) begin
            state_reg <= S_IDLE;
            cmd_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state_reg <= S_W_OPND;
            cmd_ready <= 1'b0;
          end
        end
        S_W_OPND:  if (acc_done) state_reg <= S_W_CLR1;
        S_W_CLR1:  if (acc_done) state_reg <= S_W_CLR0;
        S_W_CLR0:  if (acc_done) state_reg <= S_W_START;
        S_W_START: begin
          if (acc_done) begin
            state_reg <= S_WAIT_INT;
            cnt_reg   <= '0;
          end
        end
        S_WAIT_INT: begin
          cnt_reg <= cnt_next;
          if (int_rise) begin
            res_cycles <= cnt_next;
            state_reg  <= S_R_H;
          end
        end
        S_R_H: begin
          if (acc_done) begin
            res_h     <= acc_rd_data;
            state_reg <= S_R_L;
          end
        end
        S_R_L: begin
          if (acc_done) begin
            res_l         <= acc_rd_data;
            clr_phase_reg <= 1'b0;
            state_reg     <= S_W_CLR_DONE;
          end
        end
        S_W_CLR_DONE: begin
          if (acc_done) begin
            if (!clr_phase_reg) begin
              clr_phase_reg <= 1'b1;
            end else begin
              state_reg <= S_OUT;
              res_valid <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fac_master.sv
// Directed bench for fac_master with a behavioural calculator on the bus.
module tb_fac_master;

  localparam logic [15:0] A_START = 16'h7000;
  localparam logic [15:0] A_CLR   = 16'h7008;
  localparam logic [15:0] A_INTEN = 16'h7018;
  localparam logic [15:0] A_OPND  = 16'h7020;
  localparam logic [15:0] A_RH    = 16'h7028;
  localparam logic [15:0] A_RL    = 16'h7030;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic [63:0] cmd_operand;
  logic        cmd_ready;
  logic        res_valid;
  logic [63:0] res_h, res_l;
  logic [31:0] res_cycles;
  logic        res_ready;
  logic        m_req, m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic        m_grant;
  logic [63:0] m_din;
  logic        interrupt;

  int n_checks = 0;
  int n_errors = 0;

  // calculator model state
  logic        intren_m = 1'b0;
  logic        done_m   = 1'b0;
  logic        busy_m   = 1'b0;
  logic [63:0] opnd_m   = '0;
  logic [63:0] rh_m     = '0;
  logic [63:0] rl_m     = '0;
  int          cnt_m    = 0;
  int          calc_delay = 3;
  bit          auto_m   = 1'b1;
  logic        force_int = 1'b0;

  logic [15:0] log_addr[$];
  logic        log_wr[$];
  logic [63:0] log_data[$];

  always #5 clk = ~clk;

  fac_master #(.BASE(16'h7000), .CNT_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_operand(cmd_operand),
    .cmd_ready  (cmd_ready),
    .res_valid  (res_valid),
    .res_h      (res_h),
    .res_l      (res_l),
    .res_cycles (res_cycles),
    .res_ready  (res_ready),
    .m_req      (m_req),
    .m_wr       (m_wr),
    .m_addr     (m_addr),
    .m_dout     (m_dout),
    .m_grant    (m_grant),
    .m_din      (m_din),
    .interrupt  (interrupt)
  );

  function automatic logic [127:0] fact128(input logic [63:0] n);
    logic [127:0] p;
    p = 128'd1;
    for (int i = 2; i <= 40; i++)
      if (64'(i) <= n) p = p * 128'(i);
    return p;
  endfunction

  assign interrupt = intren_m & (done_m | force_int);

  always_comb begin
    m_din = 64'd0;
    if (m_addr == A_RH)      m_din = rh_m;
    else if (m_addr == A_RL) m_din = rl_m;
  end

  // Behavioural calculator: register writes, delayed completion, access log
  always @(posedge clk) begin
    if (m_req && m_grant) begin
      log_addr.push_back(m_addr);
      log_wr.push_back(m_wr);
      log_data.push_back(m_dout);
      if (m_wr) begin
        if (m_addr == A_INTEN) intren_m <= m_dout[0];
        if (m_addr == A_OPND)  opnd_m   <= m_dout;
        if (m_addr == A_CLR && m_dout[0]) done_m <= 1'b0;
        if (m_addr == A_START && m_dout[0]) begin
          {rh_m, rl_m} <= fact128(opnd_m);
          if (auto_m) begin
            busy_m <= 1'b1;
            cnt_m  <= calc_delay;
          end
        end
      end
    end
    if (busy_m) begin
      if (cnt_m == 0) begin
        busy_m <= 1'b0;
        done_m <= 1'b1;
      end else begin
        cnt_m <= cnt_m - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_wr.delete();
    log_data.delete();
  endtask

  task automatic send_cmd(input logic [63:0] op, input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " cmd_ready_wait"}, 128'(t < 300), 128'd1);
    cmd_valid   = 1'b1;
    cmd_operand = op;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic check_log(input logic [63:0] op, input string tag);
    logic [15:0] ea[8];
    logic        ew[8];
    logic [63:0] ed[8];
    ea = '{A_OPND, A_CLR, A_CLR, A_START, A_RH, A_RL, A_CLR, A_CLR};
    ew = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ed = '{op, 64'd1, 64'd0, 64'd1, 64'd0, 64'd0, 64'd1, 64'd0};
    chk({tag, " log_len"}, 128'(log_addr.size()), 128'd8);
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      chk($sformatf("%s log_addr[%0d]", tag, i), 128'(log_addr[i]), 128'(ea[i]));
      chk($sformatf("%s log_wr[%0d]", tag, i), 128'(log_wr[i]), 128'(ew[i]));
      if (ew[i]) chk($sformatf("%s log_data[%0d]", tag, i), 128'(log_data[i]), 128'(ed[i]));
    end
  endtask

  // One full command: optional CLR1 grant stall, optional manual interrupt
  // timing (lat edges after start completion), optional OUT hold cycles.
  task automatic run_vec(input logic [63:0] op, input logic [63:0] eh, input logic [63:0] el,
                         input int hold, input bit stall, input int lat, input string tag);
    int t;
    clear_log();
    auto_m = (lat == 0);
    send_cmd(op, tag);
    if (stall) begin
      t = 0;
      @(negedge clk);
      while (!(m_req && m_wr && m_addr == A_CLR && m_dout == 64'd1) && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk({tag, " clr1_seen"}, 128'(t < 50), 128'd1);
      m_grant = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk({tag, " stall_req"},  128'(m_req),  128'd1);
        chk({tag, " stall_addr"}, 128'(m_addr), 128'(A_CLR));
        chk({tag, " stall_data"}, 128'(m_dout), 128'd1);
      end
      m_grant = 1'b1;
    end
    if (lat > 0) begin
      t = 0;
      @(negedge clk);
      while (!(m_req && m_grant && m_wr && m_addr == A_START) && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk({tag, " start_seen"}, 128'(t < 50), 128'd1);
      @(posedge clk);
      repeat (lat - 1) @(posedge clk);
      #1 force_int = 1'b1;
    end
    t = 0;
    @(negedge clk);
    while (!res_valid && t < 1000) begin
      @(negedge clk);
      t++;
    end
    force_int = 1'b0;
    chk({tag, " res_valid_wait"}, 128'(t < 1000), 128'd1);
    $display("txn %s: op=%0d res_h=%0h res_l=%0h cycles=%0d", tag, op, res_h, res_l, res_cycles);
    chk({tag, " res_h"}, 128'(res_h), 128'(eh));
    chk({tag, " res_l"}, 128'(res_l), 128'(el));
    if (lat > 0) chk({tag, " res_cycles"}, 128'(res_cycles), 128'(lat));
    check_log(op, tag);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold_valid"}, 128'(res_valid), 128'd1);
      chk({tag, " hold_res_l"}, 128'(res_l), 128'(el));
      chk({tag, " hold_cmd_ready"}, 128'(cmd_ready), 128'd0);
      chk({tag, " hold_m_req"}, 128'(m_req), 128'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk({tag, " post_valid"}, 128'(res_valid), 128'd0);
    chk({tag, " post_cmd_ready"}, 128'(cmd_ready), 128'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " cmd_ready"},  128'(cmd_ready),  128'd0);
    chk({tag, " res_valid"},  128'(res_valid),  128'd0);
    chk({tag, " m_req"},      128'(m_req),      128'd0);
    chk({tag, " m_wr"},       128'(m_wr),       128'd0);
    chk({tag, " m_addr"},     128'(m_addr),     128'd0);
    chk({tag, " m_dout"},     128'(m_dout),     128'd0);
    chk({tag, " res_h"},      128'(res_h),      128'd0);
    chk({tag, " res_l"},      128'(res_l),      128'd0);
    chk({tag, " res_cycles"}, 128'(res_cycles), 128'd0);
  endtask

  task automatic check_init_write(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " init_ready"}, 128'(t < 50), 128'd1);
    chk({tag, " init_len"}, 128'(log_addr.size()), 128'd1);
    if (log_addr.size() > 0) begin
      chk({tag, " init_addr"}, 128'(log_addr[0]), 128'(A_INTEN));
      chk({tag, " init_data"}, 128'(log_data[0]), 128'd1);
    end
  endtask

  typedef struct {
    logic [63:0] operand;
    logic [63:0] exp_h;
    logic [63:0] exp_l;
    int          hold;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int t;
    vecs[0] = '{operand: 64'd10, exp_h: 64'd0, exp_l: 64'd3628800, hold: 0};
    vecs[1] = '{operand: 64'd1,  exp_h: 64'd0, exp_l: 64'd1,       hold: 0};
    vecs[2] = '{operand: 64'd0,  exp_h: 64'd0, exp_l: 64'd1,       hold: 5};
    vecs[3] = '{operand: 64'd5,  exp_h: 64'd0, exp_l: 64'd120,     hold: 0};

    reset_n     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_operand = '0;
    res_ready   = 1'b0;
    m_grant     = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    clear_log();
    reset_n = 1'b1;
    check_init_write("por");

    for (int i = 0; i < 4; i++)
      run_vec(vecs[i].operand, vecs[i].exp_h, vecs[i].exp_l, vecs[i].hold, 1'b0, 0,
              $sformatf("vec%0d", i));

    // grant withheld for three cycles during the first OPCLEAR write
    run_vec(64'd20, 64'd0, 64'h21C3677C82B40000, 0, 1'b1, 0, "stall20");

    // interrupt raised so it is first sampled 100 edges after start completes
    run_vec(64'd3, 64'd0, 64'd6, 0, 1'b0, 100, "lat100");

    // reset pulsed while waiting for the interrupt
    clear_log();
    auto_m = 1'b0;
    send_cmd(64'd7, "rst");
    t = 0;
    @(negedge clk);
    while (!(m_req && m_grant && m_addr == A_START) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rst start_seen", 128'(t < 50), 128'd1);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    clear_log();
    reset_n = 1'b1;
    check_init_write("midrst");
    auto_m = 1'b1;
    run_vec(64'd4, 64'd0, 64'd24, 0, 1'b0, 0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
